// File: rtl/digit_serial_add_ctrl.sv
// Digit-serial adder controller: feeds 2-bit digits of two latched operands to an
// external 2-bit adder, one digit per clock, and assembles the sum and final carry.
module digit_serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic [1:0]       add_a,
    output logic [1:0]       add_b,
    output logic             add_cin,
    input  logic             add_sum0,
    input  logic             add_sum1,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out,
    output logic             busy
);

    localparam int DIGITS = WIDTH / 2;
    localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_r;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             run_step;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode; the adder digit always comes from the low end of the shifters
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        run_step   = 1'b0;
        add_a      = 2'b00;
        add_b      = 2'b00;
        add_cin    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                busy     = 1'b1;
                run_step = 1'b1;
                add_a    = a_sh[1:0];
                add_b    = b_sh[1:0];
                add_cin  = carry;
                if (cnt == LAST_DIGIT) begin
                    state_next = DONE;
                end else begin
                    state_next = RUN;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end else begin
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand shifters, carry, digit counter and sum assembly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            sum_r <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            carry <= cin_in;
            cnt   <= '0;
        end else if (run_step) begin
            a_sh                     <= {2'b00, a_sh[WIDTH-1:2]};
            b_sh                     <= {2'b00, b_sh[WIDTH-1:2]};
            carry                    <= add_cout;
            sum_r[{cnt, 1'b0} +: 2]  <= {add_sum1, add_sum0};
            // Saturate on the last digit; the FSM leaves RUN on the same edge
            if (cnt != LAST_DIGIT) begin
                cnt <= cnt + CNT_ONE;
            end else begin
                cnt <= cnt;
            end
        end else begin
            cnt <= cnt;
        end
    end

    assign sum_out  = sum_r;
    assign cout_out = carry;

endmodule

// File: tb/tb_digit_serial_add_ctrl.sv
// Self-checking bench for digit_serial_add_ctrl (WIDTH=8) with a modelled external
// 2-bit adder and a scoreboard of expected {carry, sum} results.
module tb_digit_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       cin_in;
    logic [1:0] add_a;
    logic [1:0] add_b;
    logic       add_cin;
    logic       add_sum0;
    logic       add_sum1;
    logic       add_cout;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum_out;
    logic       cout_out;
    logic       busy;

    int passed = 0;
    int total  = 0;
    logic [8:0] sb[$];

    digit_serial_add_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum0(add_sum0), .add_sum1(add_sum1), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum_out(sum_out), .cout_out(cout_out), .busy(busy)
    );

    // External 2-bit adder model
    assign {add_cout, add_sum1, add_sum0} = {1'b0, add_a} + {1'b0, add_b} + {2'b00, add_cin};

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_add_a"},     32'(add_a),     32'd0);
        check({tag, "_add_b"},     32'(add_b),     32'd0);
        check({tag, "_add_cin"},   32'(add_cin),   32'd0);
    endtask

    // Accept one operand pair and follow it digit by digit through RUN.
    // With keep set, in_valid stays high carrying the next operands.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic keep, input logic [7:0] na, input logic [7:0] nb,
                         input logic nc);
        int n;
        logic [7:0] as;
        logic [7:0] bs;
        logic cr;
        logic [2:0] s;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        check("ready_before_issue", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a_in = a;
        b_in = b;
        cin_in = c;
        step();
        sb.push_back({1'b0, a} + {1'b0, b} + {8'd0, c});
        if (keep) begin
            a_in = na;
            b_in = nb;
            cin_in = nc;
        end else begin
            in_valid = 1'b0;
            a_in = 8'h00;
            b_in = 8'h00;
            cin_in = 1'b0;
        end
        as = a;
        bs = b;
        cr = c;
        for (int i = 0; i < 4; i++) begin
            check("run_busy",      32'(busy),      32'd1);
            check("run_in_ready",  32'(in_ready),  32'd0);
            check("run_out_valid", 32'(out_valid), 32'd0);
            check("run_add_a",     32'(add_a),     32'(as[1:0]));
            check("run_add_b",     32'(add_b),     32'(bs[1:0]));
            check("run_add_cin",   32'(add_cin),   32'(cr));
            s = {1'b0, as[1:0]} + {1'b0, bs[1:0]} + {2'b00, cr};
            cr = s[2];
            as = as >> 2;
            bs = bs >> 2;
            step();
        end
        check("done_out_valid", 32'(out_valid), 32'd1);
        check("done_busy",      32'(busy),      32'd0);
    endtask

    // Hold out_ready low for 'hold' cycles in DONE, then complete the handshake.
    task automatic drain(input int hold);
        logic [8:0] e;
        e = 9'h000;
        check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
        end else begin
            e = 9'h000;
        end
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready",  32'(in_ready),  32'd0);
            check("hold_sum",       32'(sum_out),   32'(e[7:0]));
            check("hold_cout",      32'(cout_out),  32'(e[8]));
            step();
        end
        out_ready = 1'b1;
        check("result_out_valid", 32'(out_valid), 32'd1);
        check("result_sum",       32'(sum_out),   32'(e[7:0]));
        check("result_cout",      32'(cout_out),  32'(e[8]));
        step();
        out_ready = 1'b0;
        check("after_out_valid", 32'(out_valid), 32'd0);
        check("after_in_ready",  32'(in_ready),  32'd1);
        check("after_sum_kept",  32'(sum_out),   32'(e[7:0]));
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        a_in = 8'h00;
        b_in = 8'h00;
        cin_in = 1'b0;
        out_ready = 1'b0;
        #2;
        check_idle_outputs("reset");
        check("reset_sum",  32'(sum_out),  32'd0);
        check("reset_cout", 32'(cout_out), 32'd0);
        step();
        step();
        rst = 1'b0;

        // out_ready without out_valid does nothing
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_idle_outputs("stray_ready");
        check("stray_ready_sum", 32'(sum_out), 32'd0);

        // Basic add, then all-ones plus carry-in
        issue(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        drain(0);
        issue(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        drain(0);

        // Back-pressure in DONE
        issue(8'h12, 8'h34, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        drain(3);

        // in_valid held through RUN/DONE with new operands
        issue(8'hA7, 8'h6B, 1'b0, 1'b1, 8'hC3, 8'h5E, 1'b1);
        drain(1);
        issue(8'hC3, 8'h5E, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        drain(0);

        // Reset in the second RUN cycle discards the operation
        in_valid = 1'b1;
        a_in = 8'h77;
        b_in = 8'h99;
        cin_in = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_idle_outputs("midrun_reset");
        check("midrun_reset_sum",  32'(sum_out),  32'd0);
        check("midrun_reset_cout", 32'(cout_out), 32'd0);
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("post_reset_no_valid", 32'(out_valid), 32'd0);
            step();
        end
        issue(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        drain(0);

        // Random back-to-back operands with random back-pressure
        for (int k = 0; k < 20; k++) begin
            issue(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'b0, 8'h00, 8'h00, 1'b0);
            drain(int'($urandom_range(0, 3)));
        end

        check("sb_empty_at_end", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
